// File: rtl/tag_slot_buffer.sv
// tag_slot_buffer: slot-allocating metadata store for outstanding memory requests.
// A free slot index is offered as the request tag; the acquire stores metadata there,
// and the response tag reads it back before the slot is released.
// Optional build macro TAG_BUF_READ_REG_EN registers read_data (1-cycle latency).
module tag_slot_buffer #(
   parameter int unsigned DATAW = 32,
   parameter int unsigned SIZE  = 8,
   localparam int unsigned ADDRW = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [ADDRW-1:0] write_addr,
   input  logic             acquire_slot,
   input  logic [DATAW-1:0] write_data,
   input  logic [ADDRW-1:0] read_addr,
   output logic [DATAW-1:0] read_data,
   input  logic [ADDRW-1:0] release_addr,
   input  logic             release_slot,
   output logic             full,
   output logic             empty
);

   logic [SIZE-1:0]  used_q, used_d;
   logic [DATAW-1:0] data_q [SIZE];
   logic             do_acq;

   // Lowest-index free slot; scanning downward lets the lowest index win.
   always_comb begin
      write_addr = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (!used_q[i]) write_addr = ADDRW'(i);
      end
   end

   // Occupancy flags and qualified acquire
   always_comb begin
      full   = &used_q;
      empty  = ~|used_q;
      do_acq = acquire_slot & ~full;
   end

   // Next used mask: release first so a same-slot acquire ends up used.
   always_comb begin
      used_d = used_q;
      if (release_slot) used_d[release_addr] = 1'b0;
      if (do_acq)       used_d[write_addr]   = 1'b1;
   end

   // Used mask register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) used_q <= '0;
      else        used_q <= used_d;
   end

   // Metadata array; released slots keep their contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SIZE; i++) data_q[i] <= '0;
      end else if (do_acq) begin
         data_q[write_addr] <= write_data;
      end
   end

`ifdef TAG_BUF_READ_REG_EN
   logic [DATAW-1:0] rd_d, rd_q;

   // Capture the slot as it will look after this edge, including a same-edge acquire.
   always_comb begin
      rd_d = data_q[read_addr];
      if (do_acq && (write_addr == read_addr)) rd_d = write_data;
   end

   // Read pipeline register, free running
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_d;
   end

   assign read_data = rd_q;
`else
   // Zero-latency read; a same-cycle acquire is not forwarded.
   assign read_data = data_q[read_addr];
`endif

endmodule

// File: tb/tb_tag_slot_buffer.sv
// Self-checking bench for tag_slot_buffer: directed scenarios plus random traffic
// against an array-based reference model. Honours TAG_BUF_READ_REG_EN if defined.
module tb_tag_slot_buffer;

   localparam int DATAW = 32;
   localparam int SIZE  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       write_addr;
   logic             acquire_slot;
   logic [DATAW-1:0] write_data;
   logic [2:0]       read_addr;
   logic [DATAW-1:0] read_data;
   logic [2:0]       release_addr;
   logic             release_slot;
   logic             full;
   logic             empty;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: slot contents, occupancy flags, registered-read value
   logic [DATAW-1:0] m_data [SIZE];
   bit               m_used [SIZE];
   logic [DATAW-1:0] m_rdq;

   tag_slot_buffer #(.DATAW(DATAW), .SIZE(SIZE)) dut (
      .clk          (clk),
      .reset        (reset),
      .write_addr   (write_addr),
      .acquire_slot (acquire_slot),
      .write_data   (write_data),
      .read_addr    (read_addr),
      .read_data    (read_data),
      .release_addr (release_addr),
      .release_slot (release_slot),
      .full         (full),
      .empty        (empty)
   );

   always #5 clk = ~clk;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < SIZE; i++) c += int'(m_used[i]);
      return c;
   endfunction

   function automatic logic [2:0] exp_wa();
      for (int i = 0; i < SIZE; i++) if (!m_used[i]) return 3'(i);
      return 3'd0;
   endfunction

   function automatic logic [DATAW-1:0] exp_rd();
`ifdef TAG_BUF_READ_REG_EN
      return m_rdq;
`else
      return m_data[read_addr];
`endif
   endfunction

   function automatic logic exp_full();
      return m_count() == SIZE;
   endfunction

   function automatic logic exp_empty();
      return m_count() == 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SIZE; i++) begin
         m_data[i] = '0;
         m_used[i] = 1'b0;
      end
      m_rdq = '0;
   endtask

   // Drive one cycle's inputs (called just after a negedge) and let them settle.
   task automatic drive(input bit acq, input logic [DATAW-1:0] wd, input bit rel,
                        input logic [2:0] rel_a, input logic [2:0] rd_a);
      acquire_slot = acq;
      write_data   = wd;
      release_slot = rel;
      release_addr = rel_a;
      read_addr    = rd_a;
      #1;
   endtask

   // Advance one clock, applying the spec's rules to the model at the edge.
   task automatic tick();
      bit         was_full;
      logic [2:0] wa;
      @(posedge clk);
      if (reset) begin
         was_full = exp_full();
         wa       = exp_wa();
         if (release_slot) m_used[release_addr] = 1'b0;
         if (acquire_slot && !was_full) begin
            m_data[wa] = write_data;
            m_used[wa] = 1'b1;
         end
         m_rdq = m_data[read_addr];
      end
      @(negedge clk);
      #1;
   endtask

   // In the registered build the read result appears one clock later.
   task automatic settle_read();
`ifdef TAG_BUF_READ_REG_EN
      tick();
`endif
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      drive(1'b0, '0, 1'b0, 3'd0, 3'd0);
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_cmp++; if (write_addr !== 3'd0) begin n_fail++; $display("FAIL reset_wa: got %0d want 0", write_addr); end
      n_cmp++; if (read_data !== '0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", read_data); end
      reset = 1'b1;
      tick();
      n_cmp++; if (empty !== 1'b1 || write_addr !== 3'd0) begin
         n_fail++; $display("FAIL idle_after_reset: empty=%b wa=%0d want 1/0", empty, write_addr);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < SIZE; i++) begin
         drive(1'b1, DATAW'(32'hA0 + i), 1'b0, 3'd0, 3'd0);
         n_cmp++; if (write_addr !== 3'(i)) begin
            n_fail++; $display("FAIL fill_wa: got %0d want %0d", write_addr, i);
         end
         n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_notfull: got %b want 0", full); end
         tick();
      end
      drive(1'b0, '0, 1'b0, 3'd0, 3'd5);
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b want 0", empty); end
      settle_read();
      n_cmp++; if (read_data !== 32'hA5) begin
         n_fail++; $display("FAIL fill_rd5: got %h want 000000a5", read_data);
      end
   endtask

   task automatic test_acquire_when_full();
      drive(1'b1, 32'hFF, 1'b0, 3'd0, 3'd0);
      tick();
      for (int i = 0; i < SIZE; i++) begin
         drive(1'b0, '0, 1'b0, 3'd0, 3'(i));
         settle_read();
         n_cmp++; if (read_data !== DATAW'(32'hA0 + i)) begin
            n_fail++; $display("FAIL full_keep slot %0d: got %h want %h", i, read_data, 32'hA0 + i);
         end
      end
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_stays: got %b want 1", full); end
   endtask

   task automatic test_release_reacquire();
      drive(1'b0, '0, 1'b1, 3'd3, 3'd3);
      tick();
      drive(1'b1, 32'h33, 1'b0, 3'd0, 3'd3);
      n_cmp++; if (write_addr !== 3'd3) begin n_fail++; $display("FAIL rel3_wa: got %0d want 3", write_addr); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rel3_full: got %b want 0", full); end
`ifndef TAG_BUF_READ_REG_EN
      // Same-cycle acquire to the read slot is not forwarded.
      n_cmp++; if (read_data !== 32'hA3) begin n_fail++; $display("FAIL rel3_noforward: got %h want 000000a3", read_data); end
`endif
      tick();
      drive(1'b0, '0, 1'b0, 3'd0, 3'd3);
      settle_read();
      n_cmp++; if (read_data !== 32'h33) begin n_fail++; $display("FAIL reacq_rd: got %h want 00000033", read_data); end
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL reacq_full: got %b want 1", full); end
   endtask

   task automatic test_back_to_back();
      drive(1'b0, '0, 1'b1, 3'd7, 3'd0);
      tick();
      drive(1'b1, 32'h77, 1'b1, 3'd6, 3'd0);
      n_cmp++; if (write_addr !== 3'd7) begin n_fail++; $display("FAIL b2b_wa_before: got %0d want 7", write_addr); end
      tick();
      drive(1'b0, '0, 1'b0, 3'd0, 3'd7);
      n_cmp++; if (write_addr !== 3'd6) begin n_fail++; $display("FAIL b2b_wa_after: got %0d want 6", write_addr); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", full); end
      settle_read();
      n_cmp++; if (read_data !== 32'h77) begin n_fail++; $display("FAIL b2b_rd7: got %h want 00000077", read_data); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1,
               3'($urandom_range(0, SIZE - 1)), 3'($urandom_range(0, SIZE - 1)));
         n_cmp++; if (write_addr !== exp_wa() && !exp_full()) begin
            n_fail++; $display("FAIL rnd_wa cyc %0d: got %0d want %0d", n, write_addr, exp_wa());
         end
         n_cmp++; if (full !== exp_full() || empty !== exp_empty()) begin
            n_fail++; $display("FAIL rnd_flags cyc %0d: got full=%b empty=%b want %b/%b",
                               n, full, empty, exp_full(), exp_empty());
         end
         n_cmp++; if (read_data !== exp_rd()) begin
            n_fail++; $display("FAIL rnd_rd cyc %0d: got %h want %h", n, read_data, exp_rd());
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      reset = 1'b0;
      model_reset();
      drive(1'b0, '0, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, DATAW'(32'hC0 + i), 1'b0, 3'd0, 3'd1);
         tick();
      end
      drive(1'b0, '0, 1'b0, 3'd0, 3'd1);
      n_cmp++; if (write_addr !== 3'd3) begin n_fail++; $display("FAIL ar_pre_wa: got %0d want 3", write_addr); end
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty: got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL ar_full: got %b want 0", full); end
      n_cmp++; if (write_addr !== 3'd0) begin n_fail++; $display("FAIL ar_wa: got %0d want 0", write_addr); end
      @(posedge clk);
      #1;
      n_cmp++; if (read_data !== '0) begin n_fail++; $display("FAIL ar_rd: got %h want 0", read_data); end
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset        = 1'b0;
      acquire_slot = 1'b0;
      write_data   = '0;
      release_slot = 1'b0;
      release_addr = '0;
      read_addr    = '0;
      @(negedge clk);
      test_reset();
      test_fill();
      test_acquire_when_full();
      test_release_reacquire();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
